// File: rtl/if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg
//
// IF/ID pipeline register with a one-entry skid buffer. It takes this stage's
// own bit of the controller's stall/flush vectors. While the stage is stalled,
// the skid buffer holds one fetch response. On release, that response issues
// ahead of any newer one, so program order is kept. The block also keeps debug
// counters for stall and flush cycles, and a sticky overrun flag that records a
// response lost to a full skid buffer.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stall_i[5:0]    stall vector from the pipeline controller
//   flush_i[5:0]    flush vector from the pipeline controller
//                   (only bit STAGE_IDX of either vector is used)
//   in_valid        fetch response valid, one-cycle pulse per instruction
//   in_pc, in_inst  fetch response payload
//   in_ready        skid buffer empty; IF may issue a response
//   out_valid       ID-side instruction valid
//   out_pc, out_inst ID-side payload (0 / NOP_INST for a bubble)
//   stall_cnt_o     saturating count of stalled (and not flushed) cycles
//   flush_cnt_o     saturating count of flushed cycles
//   overrun_o       sticky flag for a response dropped while the skid was full
// ---------------------------------------------------------------------------
module if_id_stage_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INST_W    = 32,
    parameter int                 STAGE_IDX = 2,
    parameter int                 CNT_W     = 32,
    parameter logic [INST_W-1:0]  NOP_INST  = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic [5:0]        flush_i,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              overrun_o
);

    // Saturating increment. Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic              flush;
    logic              stall;
    logic              skid_vld_p0;
    logic [PC_W-1:0]   skid_pc_p0;
    logic [INST_W-1:0] skid_inst_p0;
    logic              skid_load;

    assign flush = flush_i[STAGE_IDX];
    assign stall = stall_i[STAGE_IDX];

    // The skid payload loads in two cases:
    //   - on a stall, when the skid is empty;
    //   - on an advance that drains a full skid, when a new response arrives
    //     in the same cycle (the skid refills).
    assign skid_load = !flush && in_valid &&
                       ((stall && !skid_vld_p0) || (!stall && skid_vld_p0));

    // in_ready comes from registered state only, so there is no
    // combinational path from stall_i.
    assign in_ready = ~skid_vld_p0;

    // ---- IF -> skid stage: payload register (data path, no reset) ----
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_pc_p0   <= in_pc;
            skid_inst_p0 <= in_inst;
        end
    end

    // ---- skid/IF -> ID stage: output register, skid valid and debug state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= NOP_INST;
            skid_vld_p0 <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            overrun_o   <= 1'b0;
        end else if (flush) begin
            // Flush beats stall. It drops the skid entry and any response
            // that arrives in the same cycle.
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= NOP_INST;
            skid_vld_p0 <= 1'b0;
            flush_cnt_o <= sat_inc(flush_cnt_o);
        end else if (stall) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
            if (in_valid) begin
                if (!skid_vld_p0) begin
                    skid_vld_p0 <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end else if (skid_vld_p0) begin
            // The older, buffered response issues first.
            out_valid   <= 1'b1;
            out_pc      <= skid_pc_p0;
            out_inst    <= skid_inst_p0;
            skid_vld_p0 <= in_valid;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_inst  <= in_inst;
        end else begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
        end
    end

endmodule
